banked_multi_port_memory: RTL and testbench

Parametrised successor of the multi-port memory: NumPorts request ports share NumBanks single-ported SRAM banks, word-interleaved by address. Ports that target distinct banks are served in the same cycle. Bank conflicts are resolved per bank by an arbiter, and the losing ports stall through a req/gnt handshake. The block sits between the compute datapath (operand fetch and result write-back) and on-chip storage. Reads return registered data with a valid strobe.

---
 rtl/banked_multi_port_memory.sv | 178 +++++++++++++++++
 tb/tb_banked_multi_port_memory.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_multi_port_memory.sv
// banked_multi_port_memory: NumPorts request ports sharing NumBanks word-interleaved single-port banks.
// Latency: gnt_o is combinational; read data is registered, rd_valid_o one cycle after the granting edge.
// Backpressure: each bank grants one port per cycle; losers see gnt_o=0 and hold their request.
// Option: define BANKED_MEM_RR_ARB_EN for per-bank round-robin, otherwise fixed priority (port 0 highest).
module banked_multi_port_memory #(
  parameter int DataWidth = 8,
  parameter int NumPorts  = 4,
  parameter int NumBanks  = 4,
  parameter int DataDepth = 4096,
  parameter int AddrWidth = (DataDepth <= 1) ? 1 : $clog2(DataDepth),
  parameter int BankDepth = DataDepth / NumBanks
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NumPorts-1:0]                     req_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]      addr_i,
  input  logic [NumPorts-1:0]                     we_i,
  input  logic signed [NumPorts-1:0][DataWidth-1:0] wr_data_i,
  output logic [NumPorts-1:0]                     gnt_o,
  output logic [NumPorts-1:0]                     rd_valid_o,
  output logic signed [NumPorts-1:0][DataWidth-1:0] rd_data_o
);

  localparam int BankBits = (NumBanks <= 1) ? 0 : $clog2(NumBanks);
  localparam int SelWidth = (BankBits == 0) ? 1 : BankBits;
  localparam int RowWidth = ((AddrWidth - BankBits) < 1) ? 1 : (AddrWidth - BankBits);
  localparam int PortBits = (NumPorts <= 1) ? 1 : $clog2(NumPorts);

  // per-port address decode
  logic [NumPorts-1:0][SelWidth-1:0] port_bank;
  logic [NumPorts-1:0][RowWidth-1:0] port_row;
  logic [NumPorts-1:0]               port_oor;

  // per-bank arbitration
  logic [NumBanks-1:0][NumPorts-1:0] bank_req;
  logic [NumBanks-1:0][NumPorts-1:0] bank_gnt;
  logic [NumBanks-1:0]               bank_hit;
  logic [NumBanks-1:0][PortBits-1:0] bank_win;

  // per-bank access muxed from the winning port
  logic [NumBanks-1:0][RowWidth-1:0]  bank_row;
  logic [NumBanks-1:0]                bank_we;
  logic [NumBanks-1:0]                bank_oor;
  logic [NumBanks-1:0][DataWidth-1:0] bank_wdata;
  logic [NumBanks-1:0][DataWidth-1:0] bank_q;

  // Split each address into low-order bank select and row; flag words past the end of a non-power-of-two depth
  always_comb begin
    port_bank = '0;
    port_row  = '0;
    port_oor  = '0;
    for (int p = 0; p < NumPorts; p++) begin
      port_bank[p] = SelWidth'(addr_i[p] & AddrWidth'(NumBanks - 1));
      port_row[p]  = RowWidth'(addr_i[p] >> BankBits);
      port_oor[p]  = ({1'b0, addr_i[p]} >= (AddrWidth + 1)'(DataDepth));
    end
  end

  // Route each request to its bank; requests are ignored while reset is asserted
  always_comb begin
    bank_req = '0;
    for (int b = 0; b < NumBanks; b++) begin
      for (int p = 0; p < NumPorts; p++) begin
        bank_req[b][p] = rst_ni && req_i[p] && (int'(port_bank[p]) == b);
      end
    end
  end

`ifdef BANKED_MEM_RR_ARB_EN
  logic [NumBanks-1:0][PortBits-1:0] ptr_q;

  // Round-robin pick: first requester at or above the bank pointer, wrapping; the downward scan leaves the nearest one
  always_comb begin
    bank_hit = '0;
    bank_win = '0;
    for (int b = 0; b < NumBanks; b++) begin
      for (int k = NumPorts - 1; k >= 0; k--) begin
        if (bank_req[b][PortBits'((int'(ptr_q[b]) + k) % NumPorts)]) begin
          bank_hit[b] = 1'b1;
          bank_win[b] = PortBits'((int'(ptr_q[b]) + k) % NumPorts);
        end
      end
    end
  end

  // Advance a bank's pointer past the port it just granted; idle banks keep their pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      for (int b = 0; b < NumBanks; b++) begin
        if (bank_hit[b]) begin
          ptr_q[b] <= (int'(bank_win[b]) == NumPorts - 1) ? '0 : bank_win[b] + PortBits'(1);
        end
      end
    end
  end
`else
  // Fixed priority pick: the lowest-index requester wins; the downward scan leaves it last
  always_comb begin
    bank_hit = '0;
    bank_win = '0;
    for (int b = 0; b < NumBanks; b++) begin
      for (int p = NumPorts - 1; p >= 0; p--) begin
        if (bank_req[b][p]) begin
          bank_hit[b] = 1'b1;
          bank_win[b] = PortBits'(p);
        end
      end
    end
  end
`endif

  // Expand each bank's winner into a one-hot grant
  always_comb begin
    bank_gnt = '0;
    for (int b = 0; b < NumBanks; b++) begin
      if (bank_hit[b]) begin
        bank_gnt[b][bank_win[b]] = 1'b1;
      end
    end
  end

  // A port is granted by whichever bank it addresses (only that bank can see its request)
  always_comb begin
    gnt_o = '0;
    for (int b = 0; b < NumBanks; b++) begin
      gnt_o = gnt_o | bank_gnt[b];
    end
  end

  // Steer the winning port's row, direction and data onto each bank
  always_comb begin
    bank_row   = '0;
    bank_we    = '0;
    bank_oor   = '0;
    bank_wdata = '0;
    for (int b = 0; b < NumBanks; b++) begin
      for (int p = 0; p < NumPorts; p++) begin
        if (bank_gnt[b][p]) begin
          bank_row[b]   = port_row[p];
          bank_we[b]    = we_i[p];
          bank_oor[b]   = port_oor[p];
          bank_wdata[b] = wr_data_i[p];
        end
      end
    end
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    logic [DataWidth-1:0] mem [BankDepth];

    // Single write port per bank; contents are never reset, out-of-range writes are dropped
    always_ff @(posedge clk_i) begin
      if (bank_hit[b] && bank_we[b] && !bank_oor[b]) begin
        mem[bank_row[b]] <= bank_wdata[b];
      end
    end

    assign bank_q[b] = bank_oor[b] ? '0 : mem[bank_row[b]];
  end

  // Capture read data for each granted reader; idle ports keep their last word with valid low
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_o <= '0;
      rd_data_o  <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        rd_valid_o[p] <= gnt_o[p] && !we_i[p];
        if (gnt_o[p] && !we_i[p]) begin
          rd_data_o[p] <= bank_q[port_bank[p]];
        end
      end
    end
  end

endmodule

// File: tb/tb_banked_multi_port_memory.sv
`timescale 1ns/1ps
module tb_banked_multi_port_memory;
  localparam int DW = 8;
  localparam int NP = 4;
  localparam int NB = 4;
  localparam int DD = 4096;
  localparam int AW = 12;

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic [NP-1:0]            req_i;
  logic [NP-1:0][AW-1:0]    addr_i;
  logic [NP-1:0]            we_i;
  logic signed [NP-1:0][DW-1:0] wr_data_i;
  logic [NP-1:0]            gnt_o;
  logic [NP-1:0]            rd_valid_o;
  logic signed [NP-1:0][DW-1:0] rd_data_o;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk_i = ~clk_i;

  banked_multi_port_memory #(
    .DataWidth(DW), .NumPorts(NP), .NumBanks(NB), .DataDepth(DD)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .wr_data_i(wr_data_i), .gnt_o(gnt_o), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o)
  );

  // Reference model: flat word array, per-bank pointer (stays 0 for fixed priority)
  logic [DW-1:0]         golden [DD];
  int                    m_ptr [NB];
  logic [NP-1:0]         m_gnt;
  logic [NP-1:0]         m_last_gnt;
  logic [NP-1:0]         exp_vld;
  logic [NP-1:0][DW-1:0] exp_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bank_of(input logic [AW-1:0] a);
    return int'(a) % NB;
  endfunction

  // q outranks p when it is closer (upward, wrapping) to the bank pointer
  function automatic bit beats(input int q, input int p, input int b);
    return ((q - m_ptr[b] + NP) % NP) < ((p - m_ptr[b] + NP) % NP);
  endfunction

  // A requester is granted unless another requester of the same bank outranks it
  function automatic logic [NP-1:0] model_gnt();
    logic [NP-1:0] g;
    g = '0;
    for (int p = 0; p < NP; p++) begin
      if (rst_ni && req_i[p]) begin
        g[p] = 1'b1;
        for (int q = 0; q < NP; q++) begin
          if (q != p && req_i[q] && bank_of(addr_i[q]) == bank_of(addr_i[p]) &&
              beats(q, p, bank_of(addr_i[p])))
            g[p] = 1'b0;
        end
      end
    end
    return g;
  endfunction

  always_comb m_gnt = model_gnt();

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_vld    <= '0;
      exp_data   <= '0;
      m_last_gnt <= '0;
      for (int b = 0; b < NB; b++) m_ptr[b] <= 0;
    end else begin
      m_last_gnt <= m_gnt;
      for (int p = 0; p < NP; p++) begin
        exp_vld[p] <= m_gnt[p] && !we_i[p];
        if (m_gnt[p] && !we_i[p]) exp_data[p] <= golden[addr_i[p]];
        if (m_gnt[p] && we_i[p]) golden[addr_i[p]] <= wr_data_i[p];
`ifdef BANKED_MEM_RR_ARB_EN
        if (m_gnt[p]) m_ptr[bank_of(addr_i[p])] <= (p + 1) % NP;
`endif
      end
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk_i) begin
    if (chk_en && rst_ni) begin
      check("gnt", 32'(gnt_o), 32'(m_gnt));
      check("rd_valid", 32'(rd_valid_o), 32'(exp_vld));
      for (int p = 0; p < NP; p++)
        check($sformatf("rd_data[%0d]", p), 32'(rd_data_o[p]), 32'(exp_data[p]));
    end
  end

  task automatic idle();
    req_i = '0;
    we_i  = '0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [DW-1:0] keep100;

  initial begin
    rst_ni = 1'b0;
    req_i = '1; we_i = '0; addr_i = '0; wr_data_i = '0;
    repeat (2) @(negedge clk_i);
    check("rst_gnt", 32'(gnt_o), 32'h0);
    check("rst_vld", 32'(rd_valid_o), 32'h0);
    check("rst_data", 32'(rd_data_o), 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    idle();
    chk_en = 1'b1;

    // conflict-free load then readback
    for (int i = 0; i < 1024; i++) begin
      req_i = '1; we_i = '1;
      for (int p = 0; p < NP; p++) begin
        addr_i[p]    = AW'(4 * i + p);
        wr_data_i[p] = DW'($urandom);
      end
      tick();
    end
    for (int i = 0; i < 1024; i++) begin
      req_i = '1; we_i = '0;
      for (int p = 0; p < NP; p++) addr_i[p] = AW'(4 * i + p);
      tick();
      if (i == 0) begin
        @(negedge clk_i);
        check("load_rd_vld", 32'(rd_valid_o), 32'hF);
      end
    end
    idle(); tick();

    // read-after-write
    req_i[1] = 1'b1; we_i[1] = 1'b1; addr_i[1] = AW'(7); wr_data_i[1] = 8'sh5A;
    tick();
    idle(); req_i[2] = 1'b1; addr_i[2] = AW'(7);
    tick();
    idle();
    @(negedge clk_i);
    check("raw_vld", 32'(rd_valid_o[2]), 32'h1);
    check("raw_data", 32'(rd_data_o[2]), 32'h5A);
    tick();

    // mixed conflict on bank 3
    req_i[0] = 1'b1; we_i[0] = 1'b1; addr_i[0] = AW'(3); wr_data_i[0] = 8'sh3C;
    req_i[3] = 1'b1; we_i[3] = 1'b0; addr_i[3] = AW'(3);
    @(negedge clk_i);
    check("mix_gnt0", 32'(gnt_o), 32'h1);
    tick();
    req_i[0] = 1'b0; we_i[0] = 1'b0;
    @(negedge clk_i);
    check("mix_gnt1", 32'(gnt_o), 32'h8);
    tick();
    idle();
    @(negedge clk_i);
    check("mix_vld", 32'(rd_valid_o[3]), 32'h1);
    check("mix_data", 32'(rd_data_o[3]), 32'h3C);
    tick();

    // hold behaviour
    req_i[2] = 1'b1; we_i[2] = 1'b1; addr_i[2] = AW'(10); wr_data_i[2] = 8'sh33;
    tick();
    we_i[2] = 1'b0;
    tick();
    idle();
    @(negedge clk_i);
    check("hold_first_vld", 32'(rd_valid_o[2]), 32'h1);
    check("hold_first_data", 32'(rd_data_o[2]), 32'h33);
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("hold_vld", 32'(rd_valid_o[2]), 32'h0);
      check("hold_data", 32'(rd_data_o[2]), 32'h33);
      tick();
    end

    // reset mid-burst, with a write in flight
    keep100 = golden[100];
    req_i[0] = 1'b1; addr_i[0] = AW'(7);
    tick();
    req_i[1] = 1'b1; we_i[1] = 1'b1; addr_i[1] = AW'(100); wr_data_i[1] = ~keep100;
    #2;
    check("pre_rst_vld", 32'(rd_valid_o[0]), 32'h1);
    check("pre_rst_data", 32'(rd_data_o[0]), 32'h5A);
    rst_ni = 1'b0;
    #1;
    check("rst_async_vld", 32'(rd_valid_o), 32'h0);
    check("rst_async_data", 32'(rd_data_o), 32'h0);
    tick();
    idle();
    tick();
    rst_ni = 1'b1;

    // full bank-0 conflict from fresh pointers
    req_i = '1; we_i = '0;
    for (int p = 0; p < NP; p++) addr_i[p] = AW'(4 * p);
`ifdef BANKED_MEM_RR_ARB_EN
    for (int k = 0; k < NP; k++) begin
      @(negedge clk_i);
      check("rr_gnt", 32'(gnt_o), 32'(1) << k);
      tick();
      req_i[k] = 1'b0;
    end
    req_i[0] = 1'b1;
    @(negedge clk_i);
    check("rr_regnt", 32'(gnt_o), 32'h1);
    tick();
`else
    for (int k = 0; k < NP; k++) begin
      @(negedge clk_i);
      check("fp_gnt", 32'(gnt_o), 32'h1);
      tick();
    end
    req_i[0] = 1'b0;
    @(negedge clk_i);
    check("fp_next", 32'(gnt_o), 32'h2);
    tick();
`endif
    idle(); tick();

    // the write caught by reset must not have landed
    req_i[1] = 1'b1; addr_i[1] = AW'(100);
    tick();
    idle();
    @(negedge clk_i);
    check("rst_wr_dropped", 32'(rd_data_o[1]), 32'(keep100));
    tick();

    // random traffic over a small window to force conflicts; stalled ports hold
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!(req_i[p] && !m_last_gnt[p])) begin
          req_i[p]     = ($urandom_range(0, 3) != 0);
          we_i[p]      = 1'($urandom_range(0, 1));
          addr_i[p]    = AW'($urandom_range(0, 31));
          wr_data_i[p] = DW'($urandom);
        end
      end
      tick();
    end
    idle();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
